ncl_dr_fifo: RTL

Parametrised, clocked dual-rail (NCL-encoded) pipeline stage with a DEPTH-entry token buffer and four-phase return-to-zero handshakes on both sides. It accepts W dual-rail bits from the previous stage and detects completeness (all DATA) and emptiness (all NULL) across the whole word. It stores complete tokens and re-emits them to the next stage with NULL spacers. It replaces fixed 3-bit single-stage register/controller pairs in the control path wherever buffering or wider words are needed.

---
 rtl/ncl_pkg.sv | 27 ++
 rtl/ncl_completion.sv | 48 ++++
 rtl/ncl_dr_fifo.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ncl_pkg.sv
// -----------------------------------------------------------------------------
// ncl_pkg
// Shared definitions for the NCL dual-rail FIFO stage: pair encodings and the
// state enums of the input (acknowledge) and output (emit) handshake FSMs.
// Ports: none (package).
// -----------------------------------------------------------------------------
package ncl_pkg;

   // Dual-rail pair encodings, pair = {true rail, false rail}
   localparam logic [1:0] DR_NULL = 2'b00;
   localparam logic [1:0] DR_ONE  = 2'b10;
   localparam logic [1:0] DR_ZERO = 2'b01;
   localparam logic [1:0] DR_ILL  = 2'b11;

   // Input side: what we are asking the previous stage for
   typedef enum logic {
      IN_REQ_DATA = 1'b0,
      IN_REQ_NULL = 1'b1
   } in_state_e;

   // Output side: what we are currently presenting to the next stage
   typedef enum logic {
      OUT_NULL = 1'b0,
      OUT_DATA = 1'b1
   } out_state_e;

endpackage : ncl_pkg

// File: rtl/ncl_completion.sv
// -----------------------------------------------------------------------------
// ncl_completion
// Purely combinational completion detector for a W-pair dual-rail word.
// Ports:
//   in_dr    [2*W-1:0] in  dual-rail word, pair i = in_dr[2i+1:2i]
//   all_data           out every pair is a valid data code (10 or 01)
//   all_null           out every pair is NULL (00)
//   illegal            out at least one pair is 11
// An 11 pair makes the word neither all_data nor all_null.
// -----------------------------------------------------------------------------
module ncl_completion
   import ncl_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [2*W-1:0] in_dr,
   output logic           all_data,
   output logic           all_null,
   output logic           illegal
);

   // Fold per-pair classification across the whole word
   always_comb begin
      all_data = 1'b1;
      all_null = 1'b1;
      illegal  = 1'b0;
      for (int i = 0; i < W; i++) begin
         case (in_dr[2*i +: 2])
            DR_NULL: begin
               all_data = 1'b0;
            end
            DR_ONE, DR_ZERO: begin
               all_null = 1'b0;
            end
            DR_ILL: begin
               all_data = 1'b0;
               all_null = 1'b0;
               illegal  = 1'b1;
            end
            default: begin
               all_data = 1'b0;
               all_null = 1'b0;
            end
         endcase
      end
   end

endmodule : ncl_completion

// File: rtl/ncl_dr_fifo.sv
// -----------------------------------------------------------------------------
// ncl_dr_fifo
// Clocked dual-rail (NCL) pipeline stage with a DEPTH-entry token buffer and
// four-phase return-to-zero handshakes on both sides. Complete DATA words are
// stored; stored tokens are re-emitted separated by NULL spacers.
// Ports:
//   clk                      in  clock
//   rst                      in  synchronous active-high reset
//   in_dr   [2*W-1:0]        in  dual-rail token from previous stage
//   ack_ant                  out 1 = request DATA, 0 = request NULL (upstream)
//   out_dr  [2*W-1:0]        out dual-rail token to next stage (0 = NULL)
//   ack_pos                  in  1 = next wants DATA, 0 = next wants NULL
//   count   [clog2(DEPTH+1)] out tokens currently stored
//   err                      out sticky illegal-pair flag
// Build option: define NCL_ILLEGAL_CHECK_EN to make err latch any 11 pair seen
// while requesting DATA; otherwise err is constant 0.
// -----------------------------------------------------------------------------
module ncl_dr_fifo
   import ncl_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [2*W-1:0]               in_dr,
   output logic                         ack_ant,
   output logic [2*W-1:0]               out_dr,
   input  logic                         ack_pos,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         err
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two)
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         next_ptr = {PW{1'b0}};
      end else begin
         next_ptr = p + PW'(1);
      end
   endfunction

   logic              all_data;
   logic              all_null;
   logic              illegal;

   in_state_e         in_state_q, in_state_d;
   out_state_e        out_state_q, out_state_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [2*W-1:0]    out_dr_q, out_dr_d;
   logic              ack_ant_q, ack_ant_d;
   logic              err_q, err_d;
   logic [2*W-1:0]    mem_q [DEPTH];
   logic [2*W-1:0]    mem_d [DEPTH];
   logic              wr_en;
   logic              pop_en;

   ncl_completion #(.W(W)) u_completion (
      .in_dr    (in_dr),
      .all_data (all_data),
      .all_null (all_null),
      .illegal  (illegal)
   );

   // Input handshake: accept a complete word when space exists, then wait for NULL
   always_comb begin
      in_state_d = in_state_q;
      wr_en      = 1'b0;
      case (in_state_q)
         IN_REQ_DATA: begin
            // Full uses the registered count, so a same-cycle pop frees space
            // only from the following edge.
            if (all_data && (count_q < CW'(DEPTH))) begin
               wr_en      = 1'b1;
               in_state_d = IN_REQ_NULL;
            end else begin
               in_state_d = IN_REQ_DATA;
            end
         end
         IN_REQ_NULL: begin
            if (all_null) begin
               in_state_d = IN_REQ_DATA;
            end else begin
               in_state_d = IN_REQ_NULL;
            end
         end
         default: begin
            in_state_d = IN_REQ_DATA;
         end
      endcase
      ack_ant_d = (in_state_d == IN_REQ_DATA);
   end

   // Output handshake: present head on DATA request, pop it on NULL request
   always_comb begin
      out_state_d = out_state_q;
      out_dr_d    = out_dr_q;
      pop_en      = 1'b0;
      case (out_state_q)
         OUT_NULL: begin
            if (ack_pos && (count_q != {CW{1'b0}})) begin
               out_dr_d    = mem_q[rd_ptr_q];
               out_state_d = OUT_DATA;
            end else begin
               out_state_d = OUT_NULL;
            end
         end
         OUT_DATA: begin
            if (!ack_pos) begin
               pop_en      = 1'b1;
               out_dr_d    = {(2*W){1'b0}};
               out_state_d = OUT_NULL;
            end else begin
               out_state_d = OUT_DATA;
            end
         end
         default: begin
            out_dr_d    = {(2*W){1'b0}};
            out_state_d = OUT_NULL;
         end
      endcase
   end

   // Storage, pointer and occupancy update; write and pop are independent
   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = in_dr;
         wr_ptr_d        = next_ptr(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_en) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en, pop_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

`ifdef NCL_ILLEGAL_CHECK_EN
   // Sticky flag: an 11 pair offered while DATA is requested
   always_comb begin
      if ((in_state_q == IN_REQ_DATA) && illegal) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end
`else
   logic unused_illegal;
   assign unused_illegal = illegal;

   // Illegal pairs are simply incomplete words; the flag never rises
   always_comb begin
      err_d = 1'b0;
   end
`endif

   // Control and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         in_state_q  <= IN_REQ_DATA;
         out_state_q <= OUT_NULL;
         wr_ptr_q    <= {PW{1'b0}};
         rd_ptr_q    <= {PW{1'b0}};
         count_q     <= {CW{1'b0}};
         out_dr_q    <= {(2*W){1'b0}};
         ack_ant_q   <= 1'b1;
         err_q       <= 1'b0;
      end else begin
         in_state_q  <= in_state_d;
         out_state_q <= out_state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_dr_q    <= out_dr_d;
         ack_ant_q   <= ack_ant_d;
         err_q       <= err_d;
      end
   end

   // Token storage; contents are unreachable after reset because count is 0
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign ack_ant = ack_ant_q;
   assign out_dr  = out_dr_q;
   assign count   = count_q;
   assign err     = err_q;

endmodule : ncl_dr_fifo
